lane_unpack: RTL
================

# lane_unpack

Stream-side reader for packed nibble-lane words. Accepts words of NLANES packed 4-bit lanes over a valid/ready handshake and buffers them in a 2-entry word FIFO. It emits one lane per cycle with its lane index and a last flag, applying the inverse lane transform (value − 1 mod 16) so that the original lane operand is recovered. It sits downstream of the packed lane-sum datapath and feeds per-lane consumers.

## Interface
- NLANES, default 16: lanes per word.
- WIDTH, default mypkg::WIDTH (4): bits per lane. Not overridden.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  word offered.
- in_ready  output  1  word accepted when in_valid && in_ready.
- in_data  input  NLANES*WIDTH  packed lanes; lane i = in_data[i*WIDTH +: WIDTH].
- in_count  input  $clog2(NLANES+1)  number of valid lanes, counted from lane 0.
- out_valid  output  1  lane offered.
- out_ready  input  1  lane consumed when out_valid && out_ready.
- out_data  output  WIDTH  myfun_inv(lane value) = lane − 1, mod 2^WIDTH.
- out_lane  output  $clog2(NLANES)  index of the current lane.
- out_last  output  1  current lane is the final valid lane of its word.

## Operation
- FIFO has 2 entries; each entry holds {data, clamped count}. in_count > NLANES is clamped to NLANES at push.
- in_ready = !full. It does not depend on out_ready or on a same-cycle pop, so full-FIFO pass-through is not allowed.
- Lane counter `lane` starts at 0 on the head word. Each output handshake increments it.
- out_last = (lane == count−1). On the handshake of that lane, the head is popped and lane is reset to 0.
- If the head count is 0, the head is popped in one cycle with out_valid=0 and nothing is emitted.
- out_valid = FIFO not empty && head count != 0.
- out_data, out_lane and out_last are forced to 0 whenever out_valid=0.
- While out_valid && !out_ready, all outputs hold stable.
- Push and pop in the same cycle are both honoured, and occupancy is unchanged.
- Arithmetic: out_data = lane value + {WIDTH{1'b1}}, truncated to WIDTH. 0 wraps to F.

## Timing
- Reset, or any cycle with rst=1: FIFO empty, lane=0, out_valid=0, out_data/out_lane/out_last=0, in_ready=0. in_ready rises in the first cycle after rst drops.
- Reset mid-word discards all buffered words and any partially emitted word. The current word is not completed.
- Latency: a word accepted at edge t into an empty FIFO presents lane 0 in cycle t+1.
- Throughput: 1 lane per cycle. Back-to-back words have no bubble: last lane of word A in cycle t, lane 0 of word B in cycle t+1.
- A zero-count word at the head costs exactly one bubble cycle.
- All outputs are driven from registered state (FIFO storage, pointers, lane counter) through combinational decode only. There is no combinational in→out path.

## Structure
- Shared package mypkg:
  - Add function `myfun_inv(mytype) -> mytype`, returning in−1. It is the inverse of myfun.
  - Reuse WIDTH and mytype from mypkg; do not redefine them here.
- Sub-module `lane_word_fifo`:
  - Parameterized 2-entry synchronous FIFO for {data, count}.
  - Ports: push/pop, full/empty, head outputs.
- lane_unpack top holds:
  - count clamp;
  - lane counter;
  - pop/skip logic;
  - output decode via myfun_inv.

## Test plan
- Full word:
  - Stimulus: after reset, push in_data=64'h0123_4567_89AB_CDEF, count=16, out_ready=1.
  - Response: cycles 1..16 give out_data E,D,C,…,0,F on lanes 0..15; out_last only on lane 15.
- Partial word:
  - Stimulus: push count=3, in_data low nibbles 0,1,2.
  - Response: out_data F,0,1 on lanes 0,1,2; out_last on lane 2; next cycle out_valid=0.
- Backpressure:
  - Stimulus: push 3 words while out_ready=0.
  - Response: first two accepted, then in_ready=0 and the third is held by the source. Lane 0 of word 1 holds stable for every out_ready=0 cycle.
- Zero-count skip:
  - Stimulus: words A(count 2), Z(count 0), B(count 1), out_ready=1.
  - Response: outputs A0, A1, one out_valid=0 cycle, then B0 with out_last=1.
- Clamp:
  - Stimulus: in_count=20 with NLANES=16.
  - Response: exactly 16 lanes emitted; out_last on lane 15.
- Reset mid-word:
  - Stimulus: assert rst while lane=5 of a 16-lane word, with a second word queued.
  - Response: next cycle out_valid=0 and in_ready=0. After rst drops, no stale lanes appear and a new word starts at lane 0.

Source files
------------

// File: rtl/mypkg.sv
// mypkg: shared lane type, lane width and the forward/inverse lane transforms
package mypkg;
    localparam int WIDTH = 4;
    typedef logic [WIDTH-1:0] mytype;
    function automatic mytype myfun(mytype a);
        return a + mytype'(1);
    endfunction
    function automatic mytype myfun_inv(mytype a);
        return a + {WIDTH{1'b1}};
    endfunction
endpackage

// File: rtl/lane_word_fifo.sv
// lane_word_fifo: 2-entry synchronous FIFO holding {packed lanes, lane count} per word
module lane_word_fifo #(
    parameter int DW = 64,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_data,
    input  logic [CW-1:0] push_count,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] head_count
);
    logic [DW-1:0] mem_d [2];
    logic [CW-1:0] mem_c [2];
    logic          wr_ptr, rd_ptr, do_push, do_pop;
    logic [1:0]    used;
    assign full       = used == 2'd2;
    assign empty      = used == 2'd0;
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign head_data  = mem_d[rd_ptr];
    assign head_count = mem_c[rd_ptr];
    // pointers and occupancy; simultaneous push and pop leave occupancy unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            used   <= 2'd0;
        end else begin
            wr_ptr <= wr_ptr ^ do_push;
            rd_ptr <= rd_ptr ^ do_pop;
            used   <= used + 2'(do_push) - 2'(do_pop);
        end
    end
    // word storage needs no reset: it is only read while occupancy says it is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_d[wr_ptr] <= push_data;
            mem_c[wr_ptr] <= push_count;
        end
    end
endmodule

// File: rtl/lane_unpack.sv
// lane_unpack: buffers packed nibble-lane words and emits one inverse-transformed lane per cycle
module lane_unpack import mypkg::*; #(
    parameter int NLANES = 16,
    parameter int WIDTH  = mypkg::WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NLANES*WIDTH-1:0]     in_data,
    input  logic [$clog2(NLANES+1)-1:0] in_count,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [$clog2(NLANES)-1:0]   out_lane,
    output logic                        out_last
);
    localparam int CW = $clog2(NLANES + 1);
    localparam int LW = $clog2(NLANES);
    localparam int DW = NLANES * WIDTH;
    logic [CW-1:0] cnt_clamped, head_count;
    logic [DW-1:0] head_data;
    logic [LW-1:0] lane;
    logic          full, empty, push, pop, fire, last;
    mytype         lane_val;
    lane_word_fifo #(.DW(DW), .CW(CW)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .push_data  (in_data),
        .push_count (cnt_clamped),
        .full       (full),
        .empty      (empty),
        .head_data  (head_data),
        .head_count (head_count)
    );
    assign cnt_clamped = (in_count > CW'(NLANES)) ? CW'(NLANES) : in_count;
    assign in_ready    = !rst && !full;
    assign push        = in_valid && in_ready;
    assign out_valid   = !rst && !empty && head_count != '0;
    assign fire        = out_valid && out_ready;
    assign last        = CW'(lane) == head_count - CW'(1);
    // a zero-count head is dropped without emitting; otherwise pop on the last lane's handshake
    assign pop         = !rst && !empty && (head_count == '0 || (fire && last));
    assign lane_val    = head_data[lane*WIDTH +: WIDTH];
    // output decode, forced to zero whenever no lane is offered
    always_comb begin
        out_data = out_valid ? myfun_inv(lane_val) : '0;
        out_lane = out_valid ? lane : '0;
        out_last = out_valid && last;
    end
    // lane counter walks the head word and restarts at 0 for the next one
    always_ff @(posedge clk) begin
        if (rst) lane <= '0;
        else if (fire) lane <= last ? '0 : lane + LW'(1);
    end
endmodule
